periph_uart_tx: RTL and testbench
=================================

PERIPH_UART_TX -- requirements
Module: periph_uart_tx

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_WIDTH, 16, peripheral data bus width.
- ADDR_WIDTH, 10, peripheral address bus width.
- BASE_ADDR, 0, word address of register 0.
- CLK_DIV, 868, clock cycles per serial bit (legal range >= 2).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..16).

REQ-002 SHALL have ports, one per line:
- i_clk, input, 1, single clock, rising edge.
- i_rst, input, 1, asynchronous active-high reset.
- i_addr_bus, input, ADDR_WIDTH, peripheral word address from the CPU memory/IO decoder.
- i_cs_perif, input, 1, peripheral space selected.
- i_w_r, input, 1, 1 = write cycle, 0 = read cycle.
- io_data_bus, inout, DATA_WIDTH, shared peripheral data bus.
- o_tx, output, 1, serial line, idle high.
- o_busy, output, 1, transmitter or FIFO active.

REQ-003 SHALL use a single clock (i_clk) and an asynchronous active-high reset (i_rst).

Function
REQ-004 Decode: sel = i_cs_perif && (i_addr_bus - BASE_ADDR) in {0,1}; the offset is the low address bit.
REQ-005 Offset 0 TXDATA: a write pushes io_data_bus[7:0] into the FIFO; a read returns 0.
REQ-006 Offset 1 STATUS (read): bit0 = tx active, bit1 = FIFO full, bit2 = FIFO empty, bit3 = overflow (sticky), bits[7:4] = FIFO count, upper bits 0. Writes are ignored.
REQ-007 Write sampling: the bus SHALL be sampled on every rising edge where sel && i_w_r; each such cycle is one push, with no edge detection.
REQ-008 Read drive: io_data_bus is driven combinationally while sel && !i_w_r, and is high-Z in all other cycles, including reset.
REQ-009 A push when count == FIFO_DEPTH SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle (full is evaluated on pre-pop count).
REQ-010 Overflow is cleared on the clock edge ending any cycle with a STATUS read; a dropped push in that same cycle leaves it set.
REQ-011 FIFO pointers wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH; push and pop in the same cycle (not full) leave count unchanged.
REQ-012 FSM states: IDLE, START, DATA, STOP.
- IDLE: o_tx = 1. If the FIFO is not empty, pop the head into the shift register, go to START, and load the baud counter with CLK_DIV-1.
- START: o_tx = 0 for CLK_DIV cycles, then go to DATA.
- DATA: o_tx = shift[0], LSB first, 8 bits of CLK_DIV cycles each, with a bit counter 0..7, then go to STOP.
- STOP: o_tx = 1 for CLK_DIV cycles, then go to IDLE.
REQ-013 Latency: a push at edge N into an empty idle block SHALL drive o_tx low from edge N+2 (FIFO visible at N+1, FSM leaves IDLE at N+1 edge, o_tx is registered).
REQ-014 Back-to-back bytes: STOP goes to IDLE for exactly one cycle before the next START; the frame period is 10*CLK_DIV+1 cycles.
REQ-015 o_tx SHALL be a registered output with no glitches.
REQ-016 o_busy = (state != IDLE) || FIFO not empty.
REQ-017 FIFO contents are not altered by reads; pushes never corrupt a frame in progress.

Reset
REQ-018 On i_rst the block SHALL immediately set state = IDLE, o_tx = 1, o_busy = 0, FIFO count/pointers = 0, overflow = 0, baud and bit counters = 0, and io_data_bus to high-Z.
REQ-019 Reset mid-frame SHALL abort the frame, return o_tx high, and discard FIFO contents; after release the first frame begins only after a new push.
REQ-020 No output SHALL depend on FIFO storage contents during reset; storage need not be cleared.

Verification (CLK_DIV=4, BASE_ADDR=0x200, FIFO_DEPTH=4)
REQ-021 Write 0x00A5 to 0x200 -> o_tx low from the 2nd edge after the write, then 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles; o_busy is 0 after 41 cycles.
REQ-022 Read 0x201 while idle and empty -> io_data_bus = 0x0004; with cs deasserted -> bus is Z.
REQ-023 Six back-to-back writes 0x11..0x16 -> 0x11 starts transmitting, 0x12..0x15 are queued, 0x16 is dropped; STATUS reads 0x004B, then a second read gives 0x0043; exactly five frames are output.
REQ-024 Assert i_rst for 1 cycle during the DATA bit 3 of frame 0x3C with 2 bytes queued -> o_tx = 1 asynchronously, STATUS = 0x0004, and no further frames.
REQ-025 A write to 0x202 (outside the decode) or with i_cs_perif = 0 -> no FIFO change and o_tx stays high.
REQ-026 A push into a full FIFO in the cycle IDLE pops -> push dropped, overflow = 1, count = 3 afterwards.

Source files
------------

// File: rtl/periph_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers on a shared tri-state bus,
// a small TX FIFO and an 8N1 serialiser with a registered serial output.
module periph_uart_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0,
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_addr_bus,
    input  logic                  i_cs_perif,
    input  logic                  i_w_r,
    inout  wire  [DATA_WIDTH-1:0] io_data_bus,
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] offset_s;
    logic                  sel_s, push_s, push_ok_s, pop_s, rd_stat_s;
    logic                  full_s, empty_s, active_s, drive_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic                  unused_bus_s;

    // Address decode; addresses below BASE_ADDR wrap to large offsets and miss.
    assign offset_s  = i_addr_bus - ADDR_WIDTH'(BASE_ADDR);
    assign sel_s     = i_cs_perif && (offset_s < ADDR_WIDTH'(2));
    assign push_s    = sel_s && i_w_r && !offset_s[0];
    assign rd_stat_s = sel_s && !i_w_r && offset_s[0];
    assign full_s    = (count_q == CW'(FIFO_DEPTH));
    assign empty_s   = (count_q == CW'(0));
    assign push_ok_s = push_s && !full_s;
    assign pop_s     = (state_q == IDLE) && !empty_s;
    assign active_s  = (state_q != IDLE);
    assign drive_s   = sel_s && !i_w_r && !i_rst;
    assign unused_bus_s = ^io_data_bus[DATA_WIDTH-1:8];

    // FIFO pointer, occupancy and sticky-overflow next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A dropped push wins over the clear-on-read of the same cycle.
        if (push_s && full_s) begin
            ovf_d = 1'b1;
        end else if (rd_stat_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO storage; never reset, nothing observable depends on stale entries.
    always_ff @(posedge i_clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= io_data_bus[7:0];
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            baud_q   <= BW'(0);
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Serialiser next state: every phase lasts CLK_DIV cycles counted down from CLK_DIV-1.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    state_d = START;
                    baud_d  = BW'(CLK_DIV - 1);
                    bit_d   = 3'd0;
                    shift_d = mem_q[rd_ptr_q];
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_q == BW'(0)) begin
                    state_d = DATA;
                    baud_d  = BW'(CLK_DIV - 1);
                end else begin
                    baud_d  = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (baud_q == BW'(0)) begin
                    baud_d = BW'(CLK_DIV - 1);
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                if (baud_q == BW'(0)) begin
                    state_d = IDLE;
                end else begin
                    baud_d  = baud_q - BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the next cycle, registered one cycle behind the state.
    always_comb begin
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Register read mux: TXDATA reads as zero.
    always_comb begin
        rdata_s = DATA_WIDTH'(0);
        if (offset_s[0]) begin
            rdata_s[7:0] = {4'(count_q), ovf_q, empty_s, full_s, active_s};
        end else begin
            rdata_s = DATA_WIDTH'(0);
        end
    end

    assign io_data_bus = drive_s ? rdata_s : {DATA_WIDTH{1'bz}};
    assign o_tx        = tx_q;
    assign o_busy      = active_s || !empty_s;

endmodule

// File: tb/tb_periph_uart_tx.sv
// Bench for periph_uart_tx: frame-position model of the line plus FIFO queue model,
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_periph_uart_tx;

    localparam int C  = 4;
    localparam int D  = 4;
    localparam int FT = 10 * C;
    localparam logic [9:0] BASE = 10'h200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  addr = 10'h000;
    logic        cs = 1'b0, w_r = 1'b0, drv_en = 1'b0;
    logic [15:0] drv = 16'h0000;
    tri1  [15:0] io_data_bus;
    wire         o_tx, o_busy;

    int errors = 0;
    int checks = 0;

    assign io_data_bus = drv_en ? drv : 16'hzzzz;

    always #5 clk = ~clk;

    periph_uart_tx #(
        .DATA_WIDTH(16), .ADDR_WIDTH(10), .BASE_ADDR(10'h200), .CLK_DIV(C), .FIFO_DEPTH(D)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_addr_bus(addr), .i_cs_perif(cs), .i_w_r(w_r),
        .io_data_bus(io_data_bus), .o_tx(o_tx), .o_busy(o_busy)
    );

    // ---------------- behavioural model ----------------
    // m_k counts edges since the last byte was taken for transmission.
    logic [7:0] mq[$];
    logic [7:0] m_byte = 8'h00;
    logic       m_ovf = 1'b0;
    int         m_k = FT + 1;
    wire [9:0]  m_off = addr - BASE;
    wire        m_sel = cs && (m_off < 10'd2);

    task automatic model_step();
        int  pre;
        logic psh, full, pop;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_k   = FT + 1;
            return;
        end
        pre  = mq.size();
        full = (pre == D);
        psh  = m_sel && w_r && (m_off == 10'd0);
        pop  = (m_k >= FT) && (pre > 0);
        if (psh && full) m_ovf = 1'b1;
        else if (m_sel && !w_r && m_off == 10'd1) m_ovf = 1'b0;
        if (pop) begin
            m_byte = mq.pop_front();
            m_k = 0;
        end else if (m_k <= FT) begin
            m_k++;
        end
        if (psh && !full) mq.push_back(drv[7:0]);
    endtask

    function automatic logic tx_exp();
        int idx;
        if (m_k < 1 || m_k > FT) return 1'b1;
        idx = (m_k - 1) / C;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
        return 1'b1;
    endfunction

    function automatic logic busy_exp();
        return (m_k < FT) || (mq.size() > 0);
    endfunction

    function automatic logic [15:0] status_exp();
        int n;
        n = mq.size();
        return {8'h00, 4'(n), m_ovf, (n == 0), (n == D), (m_k < FT)};
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("tx", 16'(o_tx), 16'(tx_exp()));
        chk("busy", 16'(o_busy), 16'(busy_exp()));
        if (m_sel && !w_r && !rst)
            chk("rdata", io_data_bus, (m_off == 10'd0) ? 16'h0000 : status_exp());
        else if (!drv_en)
            chk("bus_released", io_data_bus, 16'hFFFF);
    end

    // Simple serial receiver collecting decoded bytes.
    logic [7:0] rx_q[$];
    logic [7:0] rb;
    initial forever begin
        @(negedge clk);
        if (!rst && o_tx == 1'b0) begin
            repeat (C / 2) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
                repeat (C) @(negedge clk);
                rb[b] = o_tx;
            end
            repeat (C) @(negedge clk);
            rx_q.push_back(rb);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cs = 1'b0; w_r = 1'b0; drv_en = 1'b0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic c);
        addr = a; cs = c; w_r = 1'b1; drv = d; drv_en = 1'b1;
        tick();
    endtask

    task automatic rd(input logic [9:0] a, output logic [15:0] v);
        addr = a; cs = 1'b1; w_r = 1'b0; drv_en = 1'b0;
        @(negedge clk);
        v = io_data_bus;
        tick();
    endtask

    function automatic logic exp_a5(input int j);
        logic [9:0] f;
        f = {1'b1, 8'hA5, 1'b0};
        if (j < 2 || j >= 42) return 1'b1;
        return f[(j - 2) / 4];
    endfunction

    task automatic chk_rx(input string nm, input logic [7:0] first);
        chk({nm, "_count"}, 16'(rx_q.size()), 16'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            chk({nm, "_byte"}, 16'(rx_q[i]), 16'(first + 8'(i)));
    endtask

    initial begin
        logic [15:0] v;
        idle_bus();
        #1 rst = 1'b1;
        #1;
        chk("rst_tx", 16'(o_tx), 16'd1);
        chk("rst_busy", 16'(o_busy), 16'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick(); tick();

        // Single byte 0xA5: exact line waveform and busy release.
        rx_q.delete();
        wr(BASE, 16'h00A5, 1'b1);
        idle_bus();
        for (int j = 0; j < 42; j++) begin
            @(negedge clk);
            chk("a5_tx", 16'(o_tx), 16'(exp_a5(j)));
            if (j == 40) chk("a5_busy_end", 16'(o_busy), 16'd1);
            if (j == 41) chk("a5_idle", 16'(o_busy), 16'd0);
        end
        tick();
        chk("a5_rx_count", 16'(rx_q.size()), 16'd1);
        if (rx_q.size() > 0) chk("a5_rx_byte", 16'(rx_q[0]), 16'h00A5);

        // Register reads while idle; deselected bus floats.
        rd(BASE + 10'd1, v);
        chk("status_idle", v, 16'h0004);
        rd(BASE, v);
        chk("txdata_read", v, 16'h0000);
        addr = BASE + 10'd1; cs = 1'b0; w_r = 1'b0;
        @(negedge clk);
        chk("bus_z_cs0", io_data_bus, 16'hFFFF);
        tick();

        // Writes outside the decode or without chip select do nothing.
        wr(10'h202, 16'h0055, 1'b1);
        wr(BASE, 16'h0066, 1'b0);
        idle_bus();
        rd(BASE + 10'd1, v);
        chk("status_nowrite", v, 16'h0004);
        idle_bus();
        repeat (3) tick();
        chk("tx_still_high", 16'(o_tx), 16'd1);

        // Six back-to-back writes: one in flight, four queued, one dropped.
        rx_q.delete();
        for (int i = 0; i < 6; i++) wr(BASE, 16'h0011 + 16'(i), 1'b1);
        rd(BASE + 10'd1, v);
        chk("status_ovf", v, 16'h004B);
        rd(BASE + 10'd1, v);
        chk("status_ovf_clr", v, 16'h0043);
        idle_bus();
        repeat (5 * (FT + 1) + 20) tick();
        chk_rx("burst_rx", 8'h11);

        // Push into a full FIFO on the very edge the transmitter pops.
        rx_q.delete();
        for (int i = 0; i < 5; i++) wr(BASE, 16'h0021 + 16'(i), 1'b1);
        idle_bus();
        repeat (37) tick();
        wr(BASE, 16'h0026, 1'b1);
        rd(BASE + 10'd1, v);
        chk("status_pop_full", v, 16'h0039);
        idle_bus();
        repeat (5 * (FT + 1) + 20) tick();
        chk_rx("popfull_rx", 8'h21);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        rx_q.delete();
        wr(BASE, 16'h003C, 1'b1);
        wr(BASE, 16'h00AA, 1'b1);
        wr(BASE, 16'h0055, 1'b1);
        idle_bus();
        repeat (17) tick();
        rst = 1'b1;
        #1;
        chk("midrst_tx", 16'(o_tx), 16'd1);
        chk("midrst_busy", 16'(o_busy), 16'd0);
        tick();
        rst = 1'b0;
        tick();
        rd(BASE + 10'd1, v);
        chk("status_after_rst", v, 16'h0004);
        idle_bus();
        repeat (60) tick();
        rx_q.delete();
        repeat (100) tick();
        chk("no_frames_after_rst", 16'(rx_q.size()), 16'd0);
        chk("tx_high_after_rst", 16'(o_tx), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
